rom_port_arbiter: RTL and testbench

//  Shares one toggle-handshake SDRAM port between three ROM readers: main CPU, tile fetch and sound CPU.

---
 rtl/rom_arb_pkg.sv | 32 +++
 rtl/rom_word_cache.sv | 60 ++++++
 rtl/rom_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared types for the ROM port arbiter: FSM state encoding, reader IDs and
// the round-robin successor helper.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    typedef enum logic [1:0] {
        RID_CPU,
        RID_TILE,
        RID_SND
    } rid_t;

    // Round-robin order: CPU -> TILE -> SND -> CPU
    function automatic rid_t rid_next(input rid_t r);
        case (r)
            RID_CPU:  return RID_TILE;
            RID_TILE: return RID_SND;
            default:  return RID_CPU;
        endcase
    endfunction

endpackage

// File: rtl/rom_word_cache.sv
// ---------------------------------------------------------------------------
// rom_word_cache
// One-word tagged holding register for a single ROM reader.
// Ports:
//   clk_sys, reset_n  clock, async active-low reset
//   addr_i            reader's current word address
//   fill_i            load fill_tag_i/fill_data_i and mark the tag valid
//   fill_tag_i        address the fill data belongs to
//   fill_data_i       word returned by SDRAM
//   inval_i           drop the tag (download start)
//   q_o               held word
//   valid_o           held word belongs to addr_i
//   miss_o            inverse of valid_o
// ---------------------------------------------------------------------------
module rom_word_cache #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inval_i,
    output logic [DATA_W-1:0] q_o,
    output logic              valid_o,
    output logic              miss_o
);

    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;
    logic              tag_vld_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tag_q     <= '0;
            data_q    <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            if (fill_i) begin
                tag_q  <= fill_tag_i;
                data_q <= fill_data_i;
            end
            // Invalidate wins over a coincident fill: a download has begun.
            if (inval_i) begin
                tag_vld_q <= 1'b0;
            end else if (fill_i) begin
                tag_vld_q <= 1'b1;
            end
        end
    end

    // The tag is the address latched at grant time, so a reader that moved
    // while its read was in flight sees valid=0 and misses again.
    assign valid_o = tag_vld_q && (tag_q == addr_i);
    assign miss_o  = !valid_o;
    assign q_o     = data_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
// Shares one toggle-handshake SDRAM port between the main CPU, tile fetch and
// sound CPU ROM readers, and carries ioctl download byte writes on the same
// port. Each reader has a one-word tagged holding register so repeated reads
// of the same word never reach SDRAM.
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   dl_active/dl_wr/dl_addr/dl_data   ioctl download (byte address, byte data)
//   dl_wait                     stall ioctl while a write is outstanding
//   cpu_/tile_/snd_addr         reader word addresses
//   cpu_/tile_/snd_q, *_valid   reader data and "data matches address"
//   mem_req/mem_ack             request/ack toggles (done when equal)
//   mem_a/mem_we/mem_ds/mem_d   SDRAM address, write enable, byte enables, data
//   mem_q                       SDRAM read data, valid when ack matches
// ---------------------------------------------------------------------------
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W:0]   dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_valid,
    input  logic [ADDR_W-1:0] tile_addr,
    output logic [DATA_W-1:0] tile_q,
    output logic              tile_valid,
    input  logic [ADDR_W-1:0] snd_addr,
    output logic [DATA_W-1:0] snd_q,
    output logic              snd_valid,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [1:0]        mem_ds,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    state_t            state_q;
    rid_t              rr_q;
    rid_t              grant_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [1:0]        mem_ds_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [DATA_W-1:0] mem_d_q;
    logic              dl_wait_q;
    logic              dl_wr_q;
    logic              dl_act_q;
    logic              wr_pend_q;
    logic [ADDR_W:0]   pend_addr_q;
    logic [7:0]        pend_data_q;

    logic [ADDR_W-1:0] rd_addr [NREQ];
    logic [DATA_W-1:0] rd_q    [NREQ];
    logic [NREQ-1:0]   rd_valid;
    logic [NREQ-1:0]   rd_miss;
    logic [NREQ-1:0]   fill_v;

    logic              dl_wr_rise;
    logic              dl_act_rise;
    logic              wr_go;
    logic [ADDR_W:0]   wr_addr;
    logic [7:0]        wr_data;
    logic              ack_match;
    logic              rd_done;
    logic              gnt_vld;
    rid_t              gnt;
    logic [ADDR_W-1:0] gnt_addr;

    assign rd_addr[RID_CPU]  = cpu_addr;
    assign rd_addr[RID_TILE] = tile_addr;
    assign rd_addr[RID_SND]  = snd_addr;

    assign dl_wr_rise  = dl_wr && !dl_wr_q;
    assign dl_act_rise = dl_active && !dl_act_q;
    // A held edge and a fresh one are mutually exclusive while ioctl honours dl_wait.
    assign wr_go       = dl_active && (dl_wr_rise || wr_pend_q);
    assign wr_addr     = dl_wr_rise ? dl_addr : pend_addr_q;
    assign wr_data     = dl_wr_rise ? dl_data : pend_data_q;
    assign ack_match   = (mem_ack == mem_req_q);
    assign rd_done     = (state_q == RD_WAIT) && ack_match;

    // Round-robin search starting at rr_q for the first missing reader.
    always_comb begin
        rid_t r;
        r       = rr_q;
        gnt     = rr_q;
        gnt_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && rd_miss[r]) begin
                gnt     = r;
                gnt_vld = 1'b1;
            end
            r = rid_next(r);
        end
    end

    assign gnt_addr = rd_addr[gnt];

    always_comb begin
        fill_v = '0;
        for (int k = 0; k < NREQ; k++) begin
            fill_v[k] = rd_done && (grant_q == rid_t'(k));
        end
    end

    // mem_a_q still holds the granted address during RD_WAIT, so it is the
    // pending tag written alongside the returned word.
    for (genvar g = 0; g < NREQ; g++) begin : g_cache
        rom_word_cache #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_cache (
            .clk_sys     (clk_sys),
            .reset_n     (reset_n),
            .addr_i      (rd_addr[g]),
            .fill_i      (fill_v[g]),
            .fill_tag_i  (mem_a_q),
            .fill_data_i (mem_q),
            .inval_i     (dl_act_rise),
            .q_o         (rd_q[g]),
            .valid_o     (rd_valid[g]),
            .miss_o      (rd_miss[g])
        );
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESYNC;
            rr_q        <= RID_CPU;
            grant_q     <= RID_CPU;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ds_q    <= 2'b00;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
            dl_wait_q   <= 1'b0;
            dl_wr_q     <= 1'b0;
            dl_act_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            dl_wr_q  <= dl_wr;
            dl_act_q <= dl_active;

            // Hold one write edge that arrives while the port is busy.
            if (dl_active && dl_wr_rise && (state_q != IDLE)) begin
                wr_pend_q   <= 1'b1;
                pend_addr_q <= dl_addr;
                pend_data_q <= dl_data;
            end

            case (state_q)
                RESYNC: begin
                    // Absorb any handshake left in flight across reset.
                    mem_req_q <= mem_ack;
                    state_q   <= IDLE;
                end
                IDLE: begin
                    if (wr_go) begin
                        mem_a_q   <= wr_addr[ADDR_W:1];
                        mem_ds_q  <= {wr_addr[0], ~wr_addr[0]};
                        mem_d_q   <= {(DATA_W/8){wr_data}};
                        mem_we_q  <= 1'b1;
                        mem_req_q <= ~mem_req_q;
                        dl_wait_q <= 1'b1;
                        wr_pend_q <= 1'b0;
                        state_q   <= WR_WAIT;
                    end else if (!dl_active && gnt_vld) begin
                        grant_q   <= gnt;
                        rr_q      <= rid_next(gnt);
                        mem_a_q   <= gnt_addr;
                        mem_we_q  <= 1'b0;
                        mem_ds_q  <= 2'b11;
                        mem_req_q <= ~mem_req_q;
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ack_match) begin
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (ack_match) begin
                        dl_wait_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= RESYNC;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_a      = mem_a_q;
    assign mem_we     = mem_we_q;
    assign mem_ds     = mem_ds_q;
    assign mem_d      = mem_d_q;
    assign dl_wait    = dl_wait_q;
    assign cpu_q      = rd_q[RID_CPU];
    assign tile_q     = rd_q[RID_TILE];
    assign snd_q      = rd_q[RID_SND];
    assign cpu_valid  = rd_valid[RID_CPU];
    assign tile_valid = rd_valid[RID_TILE];
    assign snd_valid  = rd_valid[RID_SND];

endmodule

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_port_arbiter
// Directed bench for rom_port_arbiter with a toggle-handshake SDRAM model
// whose ack follows a request after a configurable random delay.
// ---------------------------------------------------------------------------
module tb_rom_port_arbiter;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              dl_active = 1'b0;
    logic              dl_wr = 1'b0;
    logic [ADDR_W:0]   dl_addr = '0;
    logic [7:0]        dl_data = '0;
    logic              dl_wait;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_valid;
    logic [ADDR_W-1:0] tile_addr = '0;
    logic [DATA_W-1:0] tile_q;
    logic              tile_valid;
    logic [ADDR_W-1:0] snd_addr = '0;
    logic [DATA_W-1:0] snd_q;
    logic              snd_valid;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [1:0]        mem_ds;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .cpu_addr   (cpu_addr),
        .cpu_q      (cpu_q),
        .cpu_valid  (cpu_valid),
        .tile_addr  (tile_addr),
        .tile_q     (tile_q),
        .tile_valid (tile_valid),
        .snd_addr   (snd_addr),
        .snd_q      (snd_q),
        .snd_valid  (snd_valid),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_ds     (mem_ds),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    // ROM contents seen by the model.
    function automatic logic [15:0] word(input logic [ADDR_W-1:0] a);
        logic [15:0] w;
        if (a == 23'h000100) return 16'hBEEF;
        w = a[15:0] * 16'd3 + 16'h1357;
        return w;
    endfunction

    // SDRAM model: starts on req!=ack, acks lat cycles later. It only starts
    // work once reset has been high for a full cycle, like a controller that
    // is itself released after the arbiter.
    int                lat_min = 2;
    int                lat_max = 11;
    logic              busy = 1'b0;
    int                cnt = 0;
    logic              tgt = 1'b0;
    logic              rst_seen = 1'b0;
    logic [ADDR_W-1:0] cur_a = '0;
    logic              cur_we = 1'b0;
    logic [ADDR_W-1:0] log_a [$];
    logic              log_we [$];
    logic [1:0]        log_ds [$];
    logic [15:0]       log_d [$];

    always @(posedge clk_sys) begin
        rst_seen <= reset_n;
        if (busy) begin
            if (cnt <= 1) begin
                mem_ack <= tgt;
                mem_q   <= cur_we ? 16'h0000 : word(cur_a);
                busy    <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (rst_seen && reset_n && (mem_req !== mem_ack)) begin
            busy   <= 1'b1;
            cnt    <= $urandom_range(lat_max, lat_min);
            tgt    <= mem_req;
            cur_a  <= mem_a;
            cur_we <= mem_we;
            log_a.push_back(mem_a);
            log_we.push_back(mem_we);
            log_ds.push_back(mem_ds);
            log_d.push_back(mem_d);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge clk_sys);
            if ((mem_req === mem_ack) && !busy) quiet++;
            else quiet = 0;
        end
        check({tag, "_settle"}, quiet >= 4, 1);
    endtask

    task automatic wait_busy(input string tag);
        int i;
        i = 0;
        while ((mem_req === mem_ack) && i < 100) begin
            @(negedge clk_sys);
            i++;
        end
        check({tag, "_issue"}, mem_req !== mem_ack, 1);
    endtask

    task automatic wait_ack(input string tag);
        int i;
        i = 0;
        while ((mem_req !== mem_ack) && i < 100) begin
            @(negedge clk_sys);
            i++;
        end
        check({tag, "_ack"}, mem_req === mem_ack, 1);
    endtask

    task automatic wait_dlwait(input string tag, input logic lvl);
        int i;
        i = 0;
        while ((dl_wait !== lvl) && i < 100) begin
            @(negedge clk_sys);
            i++;
        end
        check(tag, dl_wait, lvl);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;
        int toggles;
        logic req0;

        // 1: reset values, then first reads and hold
        cpu_addr  = 23'h000100;
        tile_addr = 23'h002000;
        snd_addr  = 23'h003000;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_ds", mem_ds, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_d", mem_d, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_cpu_q", cpu_q, 0);
        check("rst_valids", {cpu_valid, tile_valid, snd_valid}, 0);
        reset_n = 1'b1;
        settle("t1");
        check("t1_nreads", log_a.size(), 3);
        check("t1_first_a", log_a[0], 23'h000100);
        check("t1_first_we", log_we[0], 0);
        check("t1_first_ds", log_ds[0], 2'b11);
        hits = 0;
        foreach (log_a[i]) if (log_a[i] == 23'h000100) hits++;
        check("t1_reads_0100", hits, 1);
        check("t1_cpu_q", cpu_q, 16'hBEEF);
        check("t1_cpu_valid", cpu_valid, 1);
        check("t1_tile_q", tile_q, word(23'h002000));
        check("t1_snd_valid", snd_valid, 1);
        req0 = mem_req;
        toggles = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (mem_req !== req0) toggles++;
            req0 = mem_req;
        end
        check("t1_hold_toggles", toggles, 0);

        // 2: round-robin
        n = log_a.size();
        cpu_addr = 23'h000400; tile_addr = 23'h000500; snd_addr = 23'h000600;
        settle("t2a");
        check("t2a_n", log_a.size(), n + 3);
        check("t2a_g0", log_a[n],   23'h000400);
        check("t2a_g1", log_a[n+1], 23'h000500);
        check("t2a_g2", log_a[n+2], 23'h000600);
        cpu_addr = 23'h000401; tile_addr = 23'h000501; snd_addr = 23'h000601;
        settle("t2b");
        check("t2b_g0", log_a[n+3], 23'h000401);
        check("t2b_g1", log_a[n+4], 23'h000501);
        check("t2b_g2", log_a[n+5], 23'h000601);
        tile_addr = 23'h000502;
        settle("t2c");
        check("t2c_g0", log_a[n+6], 23'h000502);
        cpu_addr = 23'h000402; tile_addr = 23'h000503; snd_addr = 23'h000602;
        settle("t2d");
        check("t2d_n", log_a.size(), n + 10);
        check("t2d_g0", log_a[n+7], 23'h000602);
        check("t2d_g1", log_a[n+8], 23'h000402);
        check("t2d_g2", log_a[n+9], 23'h000503);
        check("t2d_cpu_q", cpu_q, word(23'h000402));
        check("t2d_snd_q", snd_q, word(23'h000602));

        // 3: download writes
        n = log_a.size();
        dl_active = 1'b1;
        @(negedge clk_sys);
        check("t3_valids_drop", {cpu_valid, tile_valid, snd_valid}, 0);
        dl_addr = '0; dl_data = 8'h12; dl_wr = 1'b1;
        @(negedge clk_sys);
        check("t3_w0_wait", dl_wait, 1);
        check("t3_w0_we", mem_we, 1);
        check("t3_w0_ds", mem_ds, 2'b01);
        check("t3_w0_d", mem_d, 16'h1212);
        check("t3_w0_a", mem_a, 0);
        dl_wr = 1'b0;
        wait_dlwait("t3_w0_clear", 1'b0);
        check("t3_w0_we_clear", mem_we, 0);
        dl_addr = 24'h000001; dl_data = 8'h34; dl_wr = 1'b1;
        @(negedge clk_sys);
        check("t3_w1_wait", dl_wait, 1);
        check("t3_w1_ds", mem_ds, 2'b10);
        check("t3_w1_d", mem_d, 16'h3434);
        check("t3_w1_a", mem_a, 0);
        dl_wr = 1'b0;
        wait_dlwait("t3_w1_clear", 1'b0);
        repeat (5) @(negedge clk_sys);
        check("t3_nops", log_a.size(), n + 2);
        check("t3_log_we", {log_we[n], log_we[n+1]}, 2'b11);
        check("t3_valids", {cpu_valid, tile_valid, snd_valid}, 0);
        dl_active = 1'b0;
        settle("t3r");
        check("t3r_refill", log_a.size(), n + 5);
        check("t3r_valids", {cpu_valid, tile_valid, snd_valid}, 3'b111);

        // 4: address change during RD_WAIT
        lat_min = 6; lat_max = 6;
        n = log_a.size();
        cpu_addr = 23'h000180;
        wait_busy("t4");
        cpu_addr = 23'h000200;
        wait_ack("t4");
        @(negedge clk_sys);
        check("t4_stale_valid", cpu_valid, 0);
        check("t4_stale_q", cpu_q, word(23'h000180));
        settle("t4");
        check("t4_n", log_a.size(), n + 2);
        check("t4_a0", log_a[n], 23'h000180);
        check("t4_a1", log_a[n+1], 23'h000200);
        check("t4_cpu_q", cpu_q, word(23'h000200));
        check("t4_cpu_valid", cpu_valid, 1);

        // 6: dl_wr edge during RD_WAIT
        n = log_a.size();
        cpu_addr = 23'h000300;
        wait_busy("t6");
        dl_addr = 24'h000004; dl_data = 8'h56; dl_active = 1'b1; dl_wr = 1'b1;
        @(negedge clk_sys);
        check("t6_wait_during_rd", dl_wait, 0);
        check("t6_tile_inval", tile_valid, 0);
        wait_dlwait("t6_wait_set", 1'b1);
        @(negedge clk_sys);
        check("t6_cpu_q", cpu_q, word(23'h000300));
        check("t6_n", log_a.size(), n + 2);
        check("t6_rd_first", {log_we[n], log_a[n]}, {1'b0, 23'h000300});
        check("t6_wr_a", log_a[n+1], 23'h000002);
        check("t6_wr_we", log_we[n+1], 1);
        check("t6_wr_ds", log_ds[n+1], 2'b01);
        check("t6_wr_d", log_d[n+1], 16'h5656);
        dl_wr = 1'b0;
        wait_dlwait("t6_wait_clear", 1'b0);
        dl_active = 1'b0;
        lat_min = 2; lat_max = 11;
        settle("t6r");
        check("t6r_valids", {tile_valid, snd_valid}, 2'b11);

        // 5: reset during an outstanding read
        lat_min = 2; lat_max = 2;
        n = log_a.size();
        cpu_addr = 23'h000700;
        wait_busy("t5");
        @(negedge clk_sys);
        check("t5_started", log_a.size(), n + 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_req", mem_req, 0);
        check("t5_rst_a", mem_a, 0);
        check("t5_rst_cpu", {cpu_q, cpu_valid}, 0);
        check("t5_rst_wait", dl_wait, 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        lat_min = 2; lat_max = 11;
        settle("t5");
        check("t5_n", log_a.size(), n + 4);
        check("t5_a0", log_a[n+1], 23'h000700);
        check("t5_we0", log_we[n+1], 0);
        check("t5_a1", log_a[n+2], 23'h000503);
        check("t5_a2", log_a[n+3], 23'h000602);
        check("t5_cpu_q", cpu_q, word(23'h000700));
        check("t5_valids", {cpu_valid, tile_valid, snd_valid}, 3'b111);
        check("t5_hs", mem_req === mem_ack, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
